// File: rtl/pipeline_stage_barrier.sv
// Valid/ready pipeline barrier with flush-to-bubble and a saturating stall counter.
// Define PIPE_BARRIER_SKID_EN to add a one-entry skid register (registered inReady).
module pipeline_stage_barrier #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic [CTRL_WIDTH-1:0] inCtrl,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [CTRL_WIDTH-1:0] outCtrl,
  output logic [CNT_WIDTH-1:0]  stallCount
);

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept, stall;

  assign accept = inValid && inReady;
  assign stall  = out_vld_q && !outReady;

`ifdef PIPE_BARRIER_SKID_EN
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

  assign inReady = !skid_vld_q;

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      out_ctrl_d = '0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || outReady) begin
      // Output slot frees up: the older skid entry goes first to keep ordering.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_ctrl_d = skid_ctrl_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_data_d = inData;
        out_ctrl_d = inCtrl;
      end else begin
        out_vld_d  = 1'b0;
        out_ctrl_d = '0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_data_d = inData;
      skid_ctrl_d = inCtrl;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end
`else
  assign inReady = outReady || !out_vld_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      out_ctrl_d = '0;
    end else if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = inData;
      out_ctrl_d = inCtrl;
    end else if (out_vld_q && outReady) begin
      out_vld_d  = 1'b0;
      out_ctrl_d = '0;
    end
  end
`endif

  // Saturates at all-ones; only reset clears it.
  assign cnt_d = (stall && (cnt_q != {CNT_WIDTH{1'b1}})) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      cnt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign outValid   = out_vld_q;
  assign outData    = out_data_q;
  assign outCtrl    = out_ctrl_q;
  assign stallCount = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_barrier.sv
// Randomized + directed bench for pipeline_stage_barrier against a queue-based model.
module tb_pipeline_stage_barrier;
  localparam int DW = 64, CW = 6, NW = 4;
  localparam int CMAX = (1 << NW) - 1;
`ifdef PIPE_BARRIER_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk, resetN, flush, inValid, inReady, outValid, outReady;
  logic [DW-1:0] inData, outData;
  logic [CW-1:0] inCtrl, outCtrl;
  logic [NW-1:0] stallCount;

  pipeline_stage_barrier #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .resetN(resetN), .flush(flush), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inCtrl(inCtrl), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outCtrl(outCtrl), .stallCount(stallCount));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; } item_t;
  item_t         mq[$];
  logic [DW-1:0] m_last;
  int            m_cnt;
  logic          m_acc;
  int            n_cmp, n_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic m_ready(input logic ordy);
    if (DEPTH == 2) return mq.size() < 2;
    return (mq.size() == 0) || ordy;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_cnt  = 0;
  endtask

  // Queue view: front is the output register, any second entry is the skid.
  task automatic model_edge();
    logic drain;
    m_acc = inValid && m_ready(outReady);
    drain = (mq.size() > 0) && outReady;
    if (mq.size() > 0 && !outReady && m_cnt < CMAX) m_cnt++;
    if (flush) mq.delete();
    else begin
      if (drain) void'(mq.pop_front());
      if (m_acc) mq.push_back('{inData, inCtrl});
    end
    if (mq.size() > 0) m_last = mq[0].d;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl);
    inValid = v; inData = d; inCtrl = c; outReady = ordy; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  always @(negedge clk) begin
    chk("outValid", {63'd0, outValid}, {63'd0, mq.size() > 0});
    chk("inReady", {63'd0, inReady}, {63'd0, m_ready(outReady)});
    chk("outCtrl", 64'(outCtrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
    chk("outData", outData, m_last);
    chk("stallCount", 64'(stallCount), 64'(m_cnt));
  end

  initial begin
    logic sent6;
    n_cmp = 0; n_err = 0;
    resetN = 1'b0; flush = 0; outReady = 0;
    inValid = 1'b1; inData = 64'hDEAD; inCtrl = 6'h3F;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outValid", {63'd0, outValid}, 64'd0);
    chk("rst_outData", outData, 64'd0);
    chk("rst_stallCount", 64'(stallCount), 64'd0);
    inValid = 0;
    resetN = 1'b1;
    #1;
    chk("rst_inReady", {63'd0, inReady}, 64'd1);

    // Streaming
    step(1, 64'd1, 6'h01, 1, 0); chk("stream1", outData, 64'd1);
    step(1, 64'd2, 6'h02, 1, 0); chk("stream2", outData, 64'd2);
    step(1, 64'd3, 6'h03, 1, 0); chk("stream3", outData, 64'd3);
    chk("stream_vld", {63'd0, outValid}, 64'd1);
    step(0, 64'd0, 6'h00, 1, 0);
    chk("stream_empty", {63'd0, outValid}, 64'd0);

    // Stall with a follow-on payload
    do_reset();
    step(1, 64'd5, 6'h05, 0, 0);
    sent6 = 1'b0;
    repeat (4) begin
      step(!sent6, 64'd6, 6'h06, 0, 0);
      if (m_acc) sent6 = 1'b1;
    end
    chk("stall_data", outData, 64'd5);
    chk("stall_cnt", 64'(stallCount), 64'd4);
`ifdef PIPE_BARRIER_SKID_EN
    chk("skid_inReady", {63'd0, inReady}, 64'd0);
`endif
    step(!sent6, 64'd6, 6'h06, 1, 0);
    chk("stall_next", outData, 64'd6);
    chk("stall_next_vld", {63'd0, outValid}, 64'd1);
    step(0, 64'd0, 6'h00, 1, 0);

    // Flush discards the input accepted in the same cycle
    do_reset();
    step(1, 64'h55, 6'h3F, 0, 0);
    chk("flush_pre_ctrl", 64'(outCtrl), 64'h3F);
    step(1, 64'd9, 6'h11, 0, 1);
    chk("flush_vld", {63'd0, outValid}, 64'd0);
    chk("flush_ctrl", 64'(outCtrl), 64'd0);
    repeat (3) step(0, 64'd0, 6'h00, 1, 0);
    chk("flush_no9", outData, 64'h55);

    // Saturation
    do_reset();
    step(1, 64'hA, 6'h0A, 0, 0);
    repeat (20) step(0, 64'd0, 6'h00, 0, 0);
    chk("sat_cnt", 64'(stallCount), 64'd15);
    step(0, 64'd0, 6'h00, 0, 1);
    chk("sat_flush", 64'(stallCount), 64'd15);
    do_reset();
    chk("sat_reset", 64'(stallCount), 64'd0);

    // Asynchronous reset between edges while FULL
    step(1, 64'd7, 6'h07, 0, 0);
    chk("async_pre", {63'd0, outValid}, 64'd1);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    chk("async_vld", {63'd0, outValid}, 64'd0);
    chk("async_cnt", 64'(stallCount), 64'd0);
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      else step($urandom_range(99) < 70, {$urandom, $urandom}, 6'($urandom),
                $urandom_range(99) < 60, $urandom_range(99) < 5);
    end

    step(0, 64'd0, 6'h00, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
